// File: rtl/motion_detect_pkg.sv
// rtl/motion_detect_pkg.sv - shared pixel types and default frame geometry for the motion-detect pipeline
package motion_detect_pkg;

  localparam int PIXEL_W        = 24;
  localparam int GRAY_W         = 8;
  localparam int DEFAULT_WIDTH  = 768;
  localparam int DEFAULT_HEIGHT = 576;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [GRAY_W-1:0]  gray_t;

  // Counter width for a 0..n-1 range; a single-value range still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fork_slot.sv
// rtl/fork_slot.sv - one-entry holding slot between the fork and one downstream FIFO
module fork_slot
  import motion_detect_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  pixel_t load_data,
  input  logic   full,
  output logic   wr_en,
  output pixel_t din,
  output logic   can_accept
);

  logic   valid;
  pixel_t data;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (wr_en) begin
      valid <= 1'b0;
    end
  end

  // A slot being emptied this cycle can take a new pixel on the same edge.
  assign wr_en      = valid & ~full;
  assign din        = data;
  assign can_accept = ~valid | wr_en;

endmodule

// File: rtl/pixel_fork.sv
// rtl/pixel_fork.sv - duplicates input FIFO pixels into grayscale and highlight branch FIFOs
// Optional raster position tracking and frame_done under PIXEL_FORK_POS_EN.
module pixel_fork
  import motion_detect_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   in_empty,
  input  pixel_t in_dout,
  output logic   in_rd_en,
  input  logic   gs_full,
  output logic   gs_wr_en,
  output pixel_t gs_din,
  input  logic   hl_full,
  output logic   hl_wr_en,
  output pixel_t hl_din
`ifdef PIXEL_FORK_POS_EN
  ,
  output logic   frame_done
`endif
);

  logic gs_can_accept;
  logic hl_can_accept;

  if (WIDTH < 1 || HEIGHT < 1) begin : g_bad_geometry
    $error("pixel_fork: WIDTH and HEIGHT must be at least 1");
  end

  // Popping during reset would lose the pixel because the slots ignore load.
  assign in_rd_en = ~reset & ~in_empty & gs_can_accept & hl_can_accept;

  fork_slot u_gs_slot (
    .clock      (clock),
    .reset      (reset),
    .load       (in_rd_en),
    .load_data  (in_dout),
    .full       (gs_full),
    .wr_en      (gs_wr_en),
    .din        (gs_din),
    .can_accept (gs_can_accept)
  );

  fork_slot u_hl_slot (
    .clock      (clock),
    .reset      (reset),
    .load       (in_rd_en),
    .load_data  (in_dout),
    .full       (hl_full),
    .wr_en      (hl_wr_en),
    .din        (hl_din),
    .can_accept (hl_can_accept)
  );

`ifdef PIXEL_FORK_POS_EN
  localparam int COL_W = cnt_width(WIDTH);
  localparam int ROW_W = cnt_width(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_col;
  logic             last_row;

  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_rd_en & last_col & last_row;
      if (in_rd_en) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_fork.sv
// tb/tb_pixel_fork.sv - randomized self-checking bench for pixel_fork against a queue-based model
module tb_pixel_fork;
  import motion_detect_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int FR = W * H;

  logic   clock = 1'b0;
  logic   reset = 1'b1;
  logic   in_empty = 1'b1;
  pixel_t in_dout = '0;
  logic   gs_full = 1'b0;
  logic   hl_full = 1'b0;
  logic   in_rd_en, gs_wr_en, hl_wr_en;
  pixel_t gs_din, hl_din;
`ifdef PIXEL_FORK_POS_EN
  logic   frame_done;
`endif

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int pop_count = 0;
  int fd_pulses = 0;
  bit fd_exp = 1'b0;

  pixel_t in_q[$];
  pixel_t sent[$];
  pixel_t gs_got[$];
  pixel_t hl_got[$];
  int     pop_cyc[$];
  int     gs_cyc[$];
  int     hl_cyc[$];

  logic   s_pop, s_gw, s_hw;
  pixel_t s_gd, s_hd;

  pixel_fork #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_empty (in_empty),
    .in_dout  (in_dout),
    .in_rd_en (in_rd_en),
    .gs_full  (gs_full),
    .gs_wr_en (gs_wr_en),
    .gs_din   (gs_din),
    .hl_full  (hl_full),
    .hl_wr_en (hl_wr_en),
    .hl_din   (hl_din)
`ifdef PIXEL_FORK_POS_EN
    ,
    .frame_done (frame_done)
`endif
  );

  always #5 clock = ~clock;

  task automatic refresh_input();
    in_empty = (in_q.size() == 0);
    in_dout  = in_empty ? '0 : in_q[0];
  endtask

  task automatic push_pixel(input pixel_t v);
    in_q.push_back(v);
    sent.push_back(v);
    refresh_input();
  endtask

  task automatic clear_model();
    in_q.delete(); sent.delete(); gs_got.delete(); hl_got.delete();
    pop_cyc.delete(); gs_cyc.delete(); hl_cyc.delete();
    refresh_input();
  endtask

  // One clock: sample at negedge, commit the modelled FIFOs at the posedge.
  task automatic step();
    @(negedge clock);
    s_pop = in_rd_en; s_gw = gs_wr_en; s_hw = hl_wr_en; s_gd = gs_din; s_hd = hl_din;
    checks += 3;
    if (s_pop === 1'b1 && in_empty) begin
      errors++; $display("FAIL pop_while_empty cycle %0d: in_rd_en=%b in_empty=%b, required no pop", cycle, s_pop, in_empty);
    end
    if (s_gw === 1'b1 && gs_full) begin
      errors++; $display("FAIL gs_write_while_full cycle %0d: gs_wr_en=%b gs_full=%b, required no write", cycle, s_gw, gs_full);
    end
    if (s_hw === 1'b1 && hl_full) begin
      errors++; $display("FAIL hl_write_while_full cycle %0d: hl_wr_en=%b hl_full=%b, required no write", cycle, s_hw, hl_full);
    end
`ifdef PIXEL_FORK_POS_EN
    checks++;
    if (frame_done !== fd_exp) begin
      errors++; $display("FAIL frame_done cycle %0d: got %b, required %b", cycle, frame_done, fd_exp);
    end
    if (frame_done === 1'b1) fd_pulses++;
`endif
    @(posedge clock);
    if (reset) begin
      pop_count = 0;
      fd_exp = 1'b0;
      gs_got.delete(); hl_got.delete();
    end else begin
      if (s_pop === 1'b1 && in_q.size() > 0) begin
        in_q.delete(0);
        pop_cyc.push_back(cycle);
        pop_count++;
      end
      fd_exp = (s_pop === 1'b1) && (pop_count % FR == 0);
      if (s_gw === 1'b1 && !gs_full) begin gs_got.push_back(s_gd); gs_cyc.push_back(cycle); end
      if (s_hw === 1'b1 && !hl_full) begin hl_got.push_back(s_hd); hl_cyc.push_back(cycle); end
    end
    cycle++;
    #1;
    refresh_input();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((in_q.size() != 0 || gs_got.size() < sent.size() || hl_got.size() < sent.size()) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++; $display("FAIL %s_drain_timeout: gs %0d hl %0d written, required %0d", name, gs_got.size(), hl_got.size(), sent.size());
    end
  endtask

  task automatic compare_seqs(input string name);
    checks += 2;
    if (gs_got.size() != sent.size()) begin
      errors++; $display("FAIL %s_gs_count: got %0d, required %0d", name, gs_got.size(), sent.size());
    end
    if (hl_got.size() != sent.size()) begin
      errors++; $display("FAIL %s_hl_count: got %0d, required %0d", name, hl_got.size(), sent.size());
    end
    for (int i = 0; i < sent.size(); i++) begin
      if (i < gs_got.size()) begin
        checks++;
        if (gs_got[i] !== sent[i]) begin
          errors++; $display("FAIL %s_gs_data[%0d]: got %h, required %h", name, i, gs_got[i], sent[i]);
        end
      end
      if (i < hl_got.size()) begin
        checks++;
        if (hl_got[i] !== sent[i]) begin
          errors++; $display("FAIL %s_hl_data[%0d]: got %h, required %h", name, i, hl_got[i], sent[i]);
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks += 5;
    if (in_rd_en !== 1'b0) begin errors++; $display("FAIL %s_in_rd_en: got %b, required 0", name, in_rd_en); end
    if (gs_wr_en !== 1'b0) begin errors++; $display("FAIL %s_gs_wr_en: got %b, required 0", name, gs_wr_en); end
    if (hl_wr_en !== 1'b0) begin errors++; $display("FAIL %s_hl_wr_en: got %b, required 0", name, hl_wr_en); end
    if (gs_din !== 24'h0) begin errors++; $display("FAIL %s_gs_din: got %h, required 000000", name, gs_din); end
    if (hl_din !== 24'h0) begin errors++; $display("FAIL %s_hl_din: got %h, required 000000", name, hl_din); end
`ifdef PIXEL_FORK_POS_EN
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL %s_frame_done: got %b, required 0", name, frame_done); end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; gs_full = 1'b0; hl_full = 1'b0;
    in_empty = 1'b0; in_dout = 24'hABCDEF;
    @(posedge clock); @(posedge clock); #1;
    check_idle_outputs("reset");
    clear_model();
    reset = 1'b0;
  endtask

  task automatic test_stream();
    clear_model();
    gs_full = 1'b0; hl_full = 1'b0;
    for (int v = 1; v <= 16; v++) push_pixel(pixel_t'(v));
    drain("stream", 100);
    compare_seqs("stream");
    for (int i = 0; i < 16 && i < pop_cyc.size(); i++) begin
      checks++;
      if (pop_cyc[i] != pop_cyc[0] + i) begin
        errors++; $display("FAIL stream_throughput[%0d]: pop cycle %0d, required %0d", i, pop_cyc[i], pop_cyc[0] + i);
      end
      if (i < gs_cyc.size()) begin
        checks++;
        if (gs_cyc[i] != pop_cyc[i] + 1) begin
          errors++; $display("FAIL stream_gs_latency[%0d]: write cycle %0d, required %0d", i, gs_cyc[i], pop_cyc[i] + 1);
        end
      end
      if (i < hl_cyc.size()) begin
        checks++;
        if (hl_cyc[i] != pop_cyc[i] + 1) begin
          errors++; $display("FAIL stream_hl_latency[%0d]: write cycle %0d, required %0d", i, hl_cyc[i], pop_cyc[i] + 1);
        end
      end
    end
  endtask

  task automatic test_hold();
    pixel_t p0;
    clear_model();
    gs_full = 1'b0; hl_full = 1'b0;
    for (int i = 0; i < 8; i++) push_pixel(pixel_t'(32'h100 + i + ($urandom_range(0, 15) << 12)));
    p0 = sent[0];
    step();
    hl_full = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checks += 3;
    if (gs_got.size() != 1) begin
      errors++; $display("FAIL hold_gs_writes: got %0d, required 1", gs_got.size());
    end
    if (pop_cyc.size() != 1) begin
      errors++; $display("FAIL hold_pops: got %0d, required 1", pop_cyc.size());
    end
    if (hl_got.size() != 0) begin
      errors++; $display("FAIL hold_hl_writes: got %0d, required 0", hl_got.size());
    end
    hl_full = 1'b0;
    step();
    checks += 3;
    if (s_pop !== 1'b1) begin errors++; $display("FAIL hold_resume_pop: got %b, required 1", s_pop); end
    if (s_hw !== 1'b1) begin errors++; $display("FAIL hold_resume_hl_wr: got %b, required 1", s_hw); end
    if (s_hd !== p0) begin errors++; $display("FAIL hold_resume_hl_din: got %h, required %h", s_hd, p0); end
    drain("hold", 100);
    compare_seqs("hold");
  endtask

  task automatic test_random();
    int n;
    clear_model();
    n = 0;
    while ((sent.size() < 1000 || in_q.size() != 0) && n < 20000) begin
      if (sent.size() < 1000 && in_q.size() < 4 && $urandom_range(0, 3) != 0)
        push_pixel(pixel_t'($urandom));
      gs_full = 1'($urandom_range(0, 1));
      hl_full = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    gs_full = 1'b0; hl_full = 1'b0;
    drain("random", 100);
    compare_seqs("random");
  endtask

  task automatic test_frame();
    reset = 1'b1; step(); reset = 1'b0;
    clear_model();
    fd_pulses = 0;
    for (int i = 0; i < 2 * FR; i++) push_pixel(pixel_t'($urandom));
    drain("frame", 200);
    step();
    compare_seqs("frame");
`ifdef PIXEL_FORK_POS_EN
    checks++;
    if (fd_pulses != 2) begin errors++; $display("FAIL frame_pulse_count: got %0d, required 2", fd_pulses); end
`endif
  endtask

  task automatic test_reset_mid();
    clear_model();
    gs_full = 1'b0; hl_full = 1'b0;
    for (int i = 0; i < 8; i++) push_pixel(pixel_t'(32'h500 + i));
    for (int k = 0; k < 5; k++) step();
    gs_full = 1'b1; hl_full = 1'b1;
    step();
    reset = 1'b1;
    step();
    gs_full = 1'b0; hl_full = 1'b0;
    #1;
    check_idle_outputs("reset_mid");
    clear_model();
    reset = 1'b0;
    fd_pulses = 0;
    for (int i = 0; i < FR; i++) push_pixel(pixel_t'($urandom));
    drain("reset_mid", 100);
    step();
    compare_seqs("reset_mid");
`ifdef PIXEL_FORK_POS_EN
    checks++;
    if (fd_pulses != 1) begin errors++; $display("FAIL reset_mid_pulse_count: got %0d, required 1", fd_pulses); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_random();
    test_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
